censor_word_hasher: RTL and testbench
=====================================

// Module: censor_word_hasher
// PURPOSE
//  Front end of the censor stream path that drives the bloom filter's write/check/hash1/hash2 interface.
//  Splits an incoming byte stream into words and computes two 8-bit hashes per word.
//  In learn mode it issues a filter write; in check mode it issues a filter check and returns hit/miss per word.
//  Sits between the AXI-stream byte input and the bloom filter; results go to the censor/replace stage.
// PARAMETERS
//  DELIM    8'h20  byte value that terminates a word (not part of the word)
//  H1_INIT  8'h00  hash1 seed loaded at reset and after each word
//  H2_INIT  8'h5A  hash2 seed loaded at reset and after each word
//  LEN_W    6      width of word-length counter (saturating)
// PORTS
//  clock             in   1      clock
//  reset             in   1      synchronous, active-high
//  mode_learn        in   1      1 = write word into filter, 0 = check word
//  s_data            in   8      input byte
//  s_valid           in   1      input byte valid
//  s_ready           out  1      input byte accepted when s_valid & s_ready
//  s_last            in   1      byte is last of packet; ends current word (byte included unless == DELIM)
//  bf_enable         out  1      filter enable
//  bf_write          out  1      filter write strobe
//  bf_check          out  1      filter check strobe
//  bf_hash1          out  8      filter hash1
//  bf_hash2          out  8      filter hash2
//  bf_word_detected  in   1      filter result, registered one cycle after check
//  res_valid         out  1      result for one checked word available
//  res_ready         in   1      result consumed when res_valid & res_ready
//  res_hit           out  1      1 = word found in filter
//  res_len           out  LEN_W  byte count of the word, saturated at 2^LEN_W-1
// BEHAVIOUR
//  Reset: clock, reset synchronous active-high.
//   All outputs 0; state ACCUM; h1=H1_INIT, h2=H2_INIT, len=0; s_ready rises the cycle after reset is released.
//  Hash update per accepted non-DELIM byte c, all arithmetic mod 256:
//   h1' = rotl1(h1) ^ c
//   h2' = (h2*31 + c), where h2*31 = (h2<<5) - h2
//  FSM states: ACCUM, ISSUE, SAMPLE, REPORT.
//   ACCUM: s_ready=1; bf_* strobes 0.
//    Accepted DELIM byte, or accepted s_last byte: if len (after including the byte) > 0,
//    latch bf_hash1/bf_hash2/res_len/mode_learn -> ISSUE; else stay in ACCUM.
//    Seeds and len reload on that same edge.
//   ISSUE (1 cycle): s_ready=0; bf_enable=1.
//    Learned mode 1: bf_write=1 -> ACCUM (no result produced).
//    Learned mode 0: bf_check=1 -> SAMPLE.
//   SAMPLE (1 cycle): bf_enable=0; capture res_hit <= bf_word_detected -> REPORT.
//   REPORT: res_valid=1; res_hit/res_len held stable; s_ready=0 (backpressure).
//    On res_ready -> ACCUM; res_valid drops the next cycle.
//  Latency: word-ending byte accepted at cycle T -> bf_check high in T+1 -> res_valid high from T+3.
//  bf_hash1/bf_hash2 remain stable from ISSUE until the next word is latched.
//  Consecutive DELIMs and a lone DELIM+s_last produce no filter access.
//  mode_learn is sampled only at word end; changes mid-word are ignored.
//  len saturates at 2^LEN_W-1; hashing continues over all bytes regardless.
//  Reset mid-word or mid-lookup: partial word discarded, FSM returns to ACCUM, no result emitted.
// TESTING
//  1. Check mode, bytes 'a','b',0x20 -> bf_check pulse with bf_hash1=0xA0, bf_hash2=0xFB; res_len=2.
//  2. Learn mode "ab " then check mode "ab " -> one bf_write pulse (hashes A0/FB);
//     then res_valid with res_hit=1, and no result emitted for the learn word.
//  3. Bytes 0x20,0x20,'x' with s_last on 'x' -> exactly one lookup (len=1); no access for the empty words.
//  4. Hold res_ready=0 for 5 cycles in REPORT -> s_ready=0 and res_* stable throughout; completes on res_ready=1.
//  5. 70-byte word with LEN_W=6 -> res_len=63; hashes match the reference model over all 70 bytes.
//  6. Assert reset during SAMPLE -> no res_valid; the next word hashes from the seeds (00/5A).

Source files
------------

// File: rtl/censor_word_hasher_if.sv
// censor_word_hasher_if: byte stream, bloom filter and result signals of the word hasher
interface censor_word_hasher_if #(parameter int LEN_W = 6);
    logic             mode_learn;
    logic [7:0]       s_data;
    logic             s_valid;
    logic             s_ready;
    logic             s_last;
    logic             bf_enable;
    logic             bf_write;
    logic             bf_check;
    logic [7:0]       bf_hash1;
    logic [7:0]       bf_hash2;
    logic             bf_word_detected;
    logic             res_valid;
    logic             res_ready;
    logic             res_hit;
    logic [LEN_W-1:0] res_len;
    modport slave (
        input  mode_learn, s_data, s_valid, s_last, bf_word_detected, res_ready,
        output s_ready, bf_enable, bf_write, bf_check, bf_hash1, bf_hash2, res_valid, res_hit, res_len
    );
    modport master (
        output mode_learn, s_data, s_valid, s_last, bf_word_detected, res_ready,
        input  s_ready, bf_enable, bf_write, bf_check, bf_hash1, bf_hash2, res_valid, res_hit, res_len
    );
endinterface

// File: rtl/censor_word_hasher.sv
// censor_word_hasher: splits a byte stream into words, hashes each word and drives bloom filter write/check
module censor_word_hasher #(
    parameter logic [7:0] DELIM   = 8'h20,
    parameter logic [7:0] H1_INIT = 8'h00,
    parameter logic [7:0] H2_INIT = 8'h5A,
    parameter int         LEN_W   = 6
) (
    input logic clock,
    input logic reset,
    censor_word_hasher_if.slave bus
);
    typedef enum logic [1:0] {ACCUM, ISSUE, SAMPLE, REPORT} state_t;
    state_t           state;
    logic [7:0]       h1, h2, h1_next, h2_next;
    logic [LEN_W-1:0] len, len_next;
    logic             accept, is_delim, word_end;
    always_comb begin
        accept   = bus.s_valid && bus.s_ready && state == ACCUM;
        is_delim = bus.s_data == DELIM;
        word_end = accept && (is_delim || bus.s_last);
        h1_next  = is_delim ? h1 : {h1[6:0], h1[7]} ^ bus.s_data;
        h2_next  = is_delim ? h2 : {h2[2:0], 5'd0} - h2 + bus.s_data;
        len_next = (is_delim || &len) ? len : len + LEN_W'(1);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ACCUM;
            h1            <= H1_INIT;
            h2            <= H2_INIT;
            len           <= '0;
            bus.s_ready   <= 1'b0;
            bus.bf_enable <= 1'b0;
            bus.bf_write  <= 1'b0;
            bus.bf_check  <= 1'b0;
            bus.bf_hash1  <= '0;
            bus.bf_hash2  <= '0;
            bus.res_valid <= 1'b0;
            bus.res_hit   <= 1'b0;
            bus.res_len   <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    bus.s_ready <= 1'b1;
                    if (word_end) begin
                        h1  <= H1_INIT;
                        h2  <= H2_INIT;
                        len <= '0;
                        // empty words (repeated delimiters) never reach the filter
                        if (len_next != '0) begin
                            bus.bf_hash1  <= h1_next;
                            bus.bf_hash2  <= h2_next;
                            bus.res_len   <= len_next;
                            bus.bf_enable <= 1'b1;
                            bus.bf_write  <= bus.mode_learn;
                            bus.bf_check  <= !bus.mode_learn;
                            bus.s_ready   <= 1'b0;
                            state         <= ISSUE;
                        end
                    end else if (accept) begin
                        h1  <= h1_next;
                        h2  <= h2_next;
                        len <= len_next;
                    end
                end
                ISSUE: begin
                    bus.bf_enable <= 1'b0;
                    bus.bf_write  <= 1'b0;
                    bus.bf_check  <= 1'b0;
                    bus.s_ready   <= bus.bf_write;
                    state         <= bus.bf_write ? ACCUM : SAMPLE;
                end
                SAMPLE: begin
                    bus.res_hit   <= bus.bf_word_detected;
                    bus.res_valid <= 1'b1;
                    state         <= REPORT;
                end
                REPORT: if (bus.res_ready) begin
                    bus.res_valid <= 1'b0;
                    bus.s_ready   <= 1'b1;
                    state         <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_censor_word_hasher.sv
// tb_censor_word_hasher: word-level reference model with per-cycle compare plus directed literal checks
module tb_censor_word_hasher;
    logic clock = 1'b0;
    logic reset = 1'b1;
    censor_word_hasher_if #(.LEN_W(6)) bus ();
    censor_word_hasher #(.LEN_W(6)) dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;

    int checks = 0, fails = 0;
    int cyc = 0, rst_cyc = 0, t_end = -100;
    bit started = 0, pend = 0, pend_learn = 0, pend_hit = 0;
    logic [15:0] exp_h = 0;
    logic [5:0]  exp_len = 0;
    logic        exp_hit = 0;
    logic [7:0]  word[$];
    bit          learned[logic [15:0]];
    bit          mem[logic [15:0]];
    int          n_checks = 0, n_writes = 0, n_res = 0;
    logic [15:0] last_ck = 0, last_wr = 0;
    logic        last_hit = 0;
    logic [5:0]  last_len = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
        logic [15:0] t;
        t = {x, x} << k;
        return t[15:8];
    endfunction

    // closed form: h1 = XOR of bytes rotated by distance from word end, h2 = seed*31^n + sum c_i*31^(n-1-i)
    function automatic logic [15:0] ref_hash(input logic [7:0] w[$]);
        logic [7:0] s1 = 8'h00;
        int s2 = 0, p = 1;
        for (int i = w.size() - 1; i >= 0; i--) begin
            s1 ^= rotl(w[i], (w.size() - 1 - i) % 8);
            s2 += int'(w[i]) * p;
            p = (p * 31) % 256;
        end
        s2 += 'h5A * p;
        return {s1, 8'(s2 % 256)};
    endfunction

    always @(posedge clock) begin
        if (bus.bf_write) mem[{bus.bf_hash1, bus.bf_hash2}] = 1'b1;
        bus.bf_word_detected <= bus.bf_check && mem.exists({bus.bf_hash1, bus.bf_hash2});
    end

    always @(negedge clock) begin
        bit acc, e_sready, e_rv;
        logic [15:0] key;
        cyc++;
        if (reset) begin
            started = 1; rst_cyc = cyc; pend = 0; word.delete();
            exp_h = 0; exp_len = 0; exp_hit = 0;
        end else if (started) begin
            acc      = pend && cyc == t_end + 1;
            e_sready = cyc >= rst_cyc + 2 && !(pend && cyc >= t_end + 1);
            e_rv     = pend && !pend_learn && cyc >= t_end + 3;
            chk("s_ready", bus.s_ready, e_sready);
            chk("bf_enable", bus.bf_enable, acc);
            chk("bf_write", bus.bf_write, acc && pend_learn);
            chk("bf_check", bus.bf_check, acc && !pend_learn);
            chk("bf_hash", {bus.bf_hash1, bus.bf_hash2}, exp_h);
            chk("res_valid", bus.res_valid, e_rv);
            chk("res_hit", bus.res_hit, exp_hit);
            chk("res_len", bus.res_len, exp_len);
            if (bus.bf_check) begin n_checks++; last_ck = {bus.bf_hash1, bus.bf_hash2}; end
            if (bus.bf_write) begin n_writes++; last_wr = {bus.bf_hash1, bus.bf_hash2}; end
            if (acc && pend_learn) pend = 0;
            if (pend && !pend_learn && cyc == t_end + 2) exp_hit = pend_hit;
            if (e_rv && bus.res_ready) begin
                pend = 0; n_res++; last_hit = bus.res_hit; last_len = bus.res_len;
            end
            if (bus.s_valid && e_sready) begin
                if (bus.s_data != 8'h20) word.push_back(bus.s_data);
                if ((bus.s_data == 8'h20 || bus.s_last) && word.size() > 0) begin
                    key = ref_hash(word);
                    pend = 1; t_end = cyc; pend_learn = bus.mode_learn;
                    pend_hit = learned.exists(key);
                    if (bus.mode_learn) learned[key] = 1'b1;
                    exp_h = key;
                    exp_len = word.size() > 63 ? 6'd63 : 6'(word.size());
                    word.delete();
                end else if (bus.s_data == 8'h20 || bus.s_last) word.delete();
            end
        end
    end

    task automatic send(input logic [7:0] c, input logic last);
        bit ok = 0;
        bus.s_data = c; bus.s_last = last; bus.s_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clock); ok = bus.s_ready;
            @(posedge clock); #1;
        end
        bus.s_valid = 1'b0; bus.s_last = 1'b0;
        if (!ok) chk("send_timeout", ok, 1);
    endtask

    task automatic send_word(input string s, input logic learn);
        bus.mode_learn = learn;
        for (int i = 0; i < s.len(); i++) send(s[i], 1'b0);
        send(8'h20, 1'b0);
    endtask

    task automatic wait_res(input int target);
        for (int k = 0; k < 30 && n_res < target; k++) @(posedge clock);
        #1 chk("res_count", 16'(n_res), 16'(target));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        logic [7:0] q[$];
        bus.s_valid = 0; bus.s_data = 0; bus.s_last = 0; bus.mode_learn = 0; bus.res_ready = 1;
        q = '{8'h61, 8'h62};
        chk("ref_ab", ref_hash(q), 16'hA0FB);
        q = '{8'h78};
        chk("ref_x", ref_hash(q), 16'h785E);
        idle(3);
        reset = 1'b0;
        idle(2);
        // 1: check mode "ab "
        send_word("ab", 1'b0);
        wait_res(1);
        chk("t1_hash", last_ck, 16'hA0FB);
        chk("t1_len", 16'(last_len), 16'd2);
        chk("t1_hit", 16'(last_hit), 16'd0);
        // 2: learn "ab " then check "ab "
        send_word("ab", 1'b1);
        idle(4);
        chk("t2_writes", 16'(n_writes), 16'd1);
        chk("t2_wr_hash", last_wr, 16'hA0FB);
        chk("t2_no_res", 16'(n_res), 16'd1);
        send_word("ab", 1'b0);
        wait_res(2);
        chk("t2_hit", 16'(last_hit), 16'd1);
        // 3: empty words then 'x' ending on s_last
        bus.mode_learn = 0;
        send(8'h20, 1'b0); send(8'h20, 1'b0); send(8'h78, 1'b1);
        wait_res(3);
        chk("t3_checks", 16'(n_checks), 16'd3);
        chk("t3_hash", last_ck, 16'h785E);
        chk("t3_len", 16'(last_len), 16'd1);
        // 4: backpressure in REPORT
        bus.res_ready = 0;
        send_word("ab", 1'b0);
        idle(8);
        chk("t4_valid_held", 16'(bus.res_valid), 16'd1);
        chk("t4_sready_low", 16'(bus.s_ready), 16'd0);
        chk("t4_no_res", 16'(n_res), 16'd3);
        bus.res_ready = 1;
        wait_res(4);
        chk("t4_hit", 16'(last_hit), 16'd1);
        // 5: 70-byte word saturates length
        q.delete();
        bus.mode_learn = 0;
        for (int i = 0; i < 70; i++) begin
            q.push_back(8'h41 + 8'(i % 26));
            send(8'h41 + 8'(i % 26), i == 69);
        end
        wait_res(5);
        chk("t5_len", 16'(last_len), 16'd63);
        chk("t5_hash", last_ck, ref_hash(q));
        // 6: reset during SAMPLE drops the lookup
        send_word("zz", 1'b0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        idle(8);
        chk("t6_no_res", 16'(n_res), 16'd5);
        send_word("ab", 1'b0);
        wait_res(6);
        chk("t6_hash", last_ck, 16'hA0FB);
        chk("t6_hit", 16'(last_hit), 16'd1);
        idle(3);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
